// File: rtl/ufp_from_f32.sv
`default_nettype none
// ============================================================================
//  Module   : ufp_from_f32
//  Brief    : Converts an IEEE-754 binary32 operand to unsigned fixed point
//             IW.QW. The mantissa is aligned 8 bits per cycle, and overflow
//             either saturates or wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module ufp_from_f32 #(
    parameter int IW   = 8,
    parameter int QW   = 8,
    parameter bit CLIP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IW+QW-1:0]   out,
    output logic               clipping
);

    localparam int c_OUT_W  = IW + QW;
    localparam int c_WORK_W = IW + QW + 24;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ALIGN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    logic [31:0]           r_in;
    logic [c_WORK_W-1:0]   r_work;
    logic [10:0]           r_rem;
    logic                  r_left;
    logic                  r_out_valid;
    logic [c_OUT_W-1:0]    r_out;
    logic                  r_clip;

    // Field decode of the captured operand
    logic                  w_s;
    logic [7:0]            w_e;
    logic [22:0]           w_f;
    logic [23:0]           w_m;
    logic [7:0]            w_e_eff;
    logic signed [10:0]    w_k;
    logic [10:0]           w_kabs;
    logic [c_WORK_W-1:0]   w_m_ext;
    logic                  w_is_zero;
    logic                  w_is_nan;
    logic                  w_is_inf;

    // Alignment step
    logic [3:0]            w_sh;
    logic [c_WORK_W-1:0]   w_shifted;
    logic [10:0]           w_rem_nxt;

    assign w_s       = r_in[31];
    assign w_e       = r_in[30:23];
    assign w_f       = r_in[22:0];
    assign w_m       = {(w_e != 8'd0), w_f};
    assign w_e_eff   = (w_e == 8'd0) ? 8'd1 : w_e;
    assign w_k       = $signed({3'b000, w_e_eff}) - 11'sd150 + $signed(11'(QW));
    assign w_kabs    = w_k[10] ? 11'(-w_k) : 11'(w_k);
    assign w_m_ext   = {{c_OUT_W{1'b0}}, w_m};
    assign w_is_zero = (w_e == 8'd0) && (w_f == 23'd0);
    assign w_is_nan  = (w_e == 8'hFF) && (w_f != 23'd0);
    assign w_is_inf  = (w_e == 8'hFF) && (w_f == 23'd0);

    assign w_sh      = (r_rem > 11'd8) ? 4'd8 : r_rem[3:0];
    assign w_shifted = r_left ? (r_work << w_sh) : (r_work >> w_sh);
    assign w_rem_nxt = r_rem - {7'd0, w_sh};

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign clipping  = r_clip;

    // Any bit above the output field after alignment is an overflow;
    // returns {clipping, out}
    function automatic logic [c_OUT_W:0] f_finalize(input logic [c_WORK_W-1:0] v);
        logic ovf;
        ovf = |v[c_WORK_W-1:c_OUT_W];
        if (ovf && CLIP)
            f_finalize = {1'b1, {c_OUT_W{1'b1}}};
        else
            f_finalize = {ovf, v[c_OUT_W-1:0]};
    endfunction

    // Conversion FSM: capture, classify, align in 8-bit steps, hold result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in        <= 32'd0;
            r_work      <= '0;
            r_rem       <= 11'd0;
            r_left      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_clip      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in    <= in;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_work <= w_m_ext;
                    r_left <= !w_k[10];
                    r_rem  <= w_kabs;
                    if (w_is_zero) begin
                        r_out       <= '0;
                        r_clip      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_is_nan || w_s) begin
                        r_out       <= '0;
                        r_clip      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_is_inf || (w_k >= $signed(11'(c_OUT_W)))) begin
                        // Shifted left by at least the output width: wrapped low bits are zero
                        r_out       <= CLIP ? {c_OUT_W{1'b1}} : {c_OUT_W{1'b0}};
                        r_clip      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_k <= -11'sd24) begin
                        // Underflow is silently zero, not a clip
                        r_out       <= '0;
                        r_clip      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_k == 11'sd0) begin
                        {r_clip, r_out} <= f_finalize(w_m_ext);
                        r_out_valid     <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_work <= w_shifted;
                    r_rem  <= w_rem_nxt;
                    if (w_rem_nxt == 11'd0) begin
                        {r_clip, r_out} <= f_finalize(w_shifted);
                        r_out_valid     <= 1'b1;
                        r_state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ufp_from_f32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ufp_from_f32
//  Brief    : Directed scoreboard bench for ufp_from_f32 (IW=8, QW=8); a
//             saturating and a wrapping instance share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ufp_from_f32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in;
    logic        out_ready;

    logic        ready_s, valid_s, clip_s;
    logic [15:0] out_s;
    logic        ready_w, valid_w, clip_w;
    logic [15:0] out_w;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] so;
        logic        sc;
        logic [15:0] wo;
        logic        wc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    ufp_from_f32 #(.IW(8), .QW(8), .CLIP(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_s), .in(in),
        .out_valid(valid_s), .out_ready(out_ready), .out(out_s), .clipping(clip_s)
    );

    ufp_from_f32 #(.IW(8), .QW(8), .CLIP(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_w), .in(in),
        .out_valid(valid_w), .out_ready(out_ready), .out(out_w), .clipping(clip_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; returns at a falling edge after the handshake
    task automatic run_op(input string tag, input logic [31:0] v,
                          input logic [15:0] so, input logic sc,
                          input logic [15:0] wo, input logic wc,
                          input int lat, input int hold);
        exp_t e;
        exp_t p;
        int   n;
        e.so = so; e.sc = sc; e.wo = wo; e.wc = wc; e.lat = lat;
        in       = v;
        in_valid = 1'b1;
        sb.push_back(e);
        #1 check({tag, ".in_ready"}, ready_s, 1'b1);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
        end while (!valid_s && n < 40);
        p = sb.pop_front();
        check({tag, ".out_valid"}, valid_s, 1'b1);
        check({tag, ".latency"}, n, p.lat);
        check({tag, ".out_sat"}, out_s, p.so);
        check({tag, ".clip_sat"}, clip_s, p.sc);
        check({tag, ".valid_wrap"}, valid_w, 1'b1);
        check({tag, ".out_wrap"}, out_w, p.wo);
        check({tag, ".clip_wrap"}, clip_w, p.wc);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, valid_s, 1'b1);
            check({tag, ".hold_out"}, out_s, p.so);
            check({tag, ".hold_clip"}, clip_s, p.sc);
            check({tag, ".hold_ready"}, ready_s, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".post_valid"}, valid_s, 1'b0);
        check({tag, ".post_ready"}, ready_s, 1'b1);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in        = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.out_valid", valid_s, 1'b0);
        check("reset.out", out_s, 16'h0000);
        check("reset.clipping", clip_s, 1'b0);
        check("reset.in_ready", ready_s, 1'b0);
        rst = 1'b0;
        #1 check("reset.release_ready", ready_s, 1'b1);

        run_op("f1p5",    32'h3FC00000, 16'h0180, 1'b0, 16'h0180, 1'b0, 4, 0);
        run_op("f300",    32'h43960000, 16'hFFFF, 1'b1, 16'h2C00, 1'b1, 3, 0);
        run_op("neg2",    32'hC0000000, 16'h0000, 1'b1, 16'h0000, 1'b1, 2, 0);
        run_op("nan",     32'h7FC00000, 16'h0000, 1'b1, 16'h0000, 1'b1, 2, 0);
        run_op("pinf",    32'h7F800000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 2, 0);
        run_op("negzero", 32'h80000000, 16'h0000, 1'b0, 16'h0000, 1'b0, 2, 0);
        run_op("uflow",   32'h3A800000, 16'h0000, 1'b0, 16'h0000, 1'b0, 2, 0);
        run_op("maxrep",  32'h437FFF00, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 3, 0);
        run_op("f65536",  32'h47800000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 3, 0);
        run_op("f32768",  32'h47000000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 2, 0);
        run_op("denorm",  32'h00000001, 16'h0000, 1'b0, 16'h0000, 1'b0, 2, 0);
        run_op("bp1p5",   32'h3FC00000, 16'h0180, 1'b0, 16'h0180, 1'b0, 4, 5);
        run_op("f1p0",    32'h3F800000, 16'h0100, 1'b0, 16'h0100, 1'b0, 4, 0);

        // Abort 300.0f with a one-cycle reset while it is aligning
        in       = 32'h43960000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check("abort.ready_in_reset", ready_s, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("abort.ready_after", ready_s, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid_s || valid_w) seen = 1'b1;
        end
        check("abort.no_result", seen, 1'b0);
        run_op("after_abort", 32'h3FC00000, 16'h0180, 1'b0, 16'h0180, 1'b0, 4, 0);

        check("scoreboard.empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ufp_from_f32.md
UFP_FROM_F32 -- requirements
Module: ufp_from_f32

Interface
REQ-001 The module SHALL have parameter IW, default 8: integer bits of the unsigned fixed-point output.
REQ-002 The module SHALL have parameter QW, default 8: fractional bits of the output, with 2 <= IW+QW <= 64.
REQ-003 The module SHALL have parameter CLIP, default 1: overflow policy, 1 = saturate, 0 = wrap (keep low IW+QW bits).
REQ-004 The module SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 The module SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The module SHALL have port in_valid  input  1  f32 operand valid.
REQ-007 The module SHALL have port in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-008 The module SHALL have port in  input  32  IEEE-754 binary32 operand.
REQ-009 The module SHALL have port out_valid  output  1  result valid.
REQ-010 The module SHALL have port out_ready  input  1  consumer ready.
REQ-011 The module SHALL have port out  output  IW+QW  raw UFP IW.QW result.
REQ-012 The module SHALL have port clipping  output  1  result is out-of-range or from a special/negative input; valid with out_valid.

Function
REQ-013 The FSM SHALL have states IDLE, DECODE, ALIGN and DONE; in_ready = (state==IDLE) && !rst.
REQ-014 On accept the module SHALL register in and enter DECODE; fields: s=in[31], e=in[30:23], f=in[22:0], M = {e!=0, f} (24 bits).
REQ-015 DECODE SHALL compute k = e_eff - 150 + QW, where e_eff = e for e != 0 and e_eff = 1 for denormals, and SHALL classify the operand.
REQ-016 Special cases SHALL go DECODE->DONE directly:
- +0/-0 -> out 0, clipping 0.
- NaN (e=255, f!=0) -> out 0, clipping 1.
- +inf -> out all-ones if CLIP else 0, clipping 1.
- any other negative -> out 0, clipping 1.
- k >= IW+QW -> overflow.
- k <= -24 -> out 0, clipping 0 (underflow is not clipping).
REQ-017 The target value SHALL be out = floor(M * 2^k), with truncation toward zero on right shifts.
REQ-018 The working register SHALL be IW+QW+24 bits wide, initialised to M.
REQ-019 ALIGN SHALL shift by min(8, remaining) bits per cycle, left if k > 0 and right if k < 0, for steps = ceil(|k|/8) cycles.
REQ-020 If steps == 0, DECODE SHALL go to DONE.
REQ-021 Overflow SHALL be defined as any working bit at position >= IW+QW set after alignment.
- CLIP=1: out = all-ones, clipping 1.
- CLIP=0: out = low IW+QW bits, clipping 1.
REQ-022 out_valid SHALL first assert exactly 2 + steps cycles after the accepting edge, where steps = 0 for the REQ-016 cases.
REQ-023 In DONE, out_valid SHALL be 1, and out and clipping SHALL be stable until out_valid && out_ready.
REQ-024 After the handshake the FSM SHALL return to IDLE, with in_ready = 1 on the following cycle and no same-cycle re-accept.
REQ-025 in_valid and in SHALL be ignored outside IDLE.
REQ-026 out_valid SHALL be 0 outside DONE.

Reset
REQ-027 While rst is high at a rising edge, the block SHALL set state = IDLE, out_valid = 0, out = 0, clipping = 0 and the working register = 0.
REQ-028 in_ready SHALL be 0 while rst is high.
REQ-029 Reset asserted in DECODE, ALIGN or DONE SHALL abort the operation without emitting a result.
REQ-030 The first cycle with rst low SHALL have in_ready = 1.

Verification (IW=8, QW=8)
REQ-031 The bench SHALL cover 1.5f, in=0x3FC00000, CLIP=1 -> out=0x0180, clipping 0, out_valid 4 cycles after accept (k=-15, 2 steps).
REQ-032 The bench SHALL cover 300.0f, in=0x43960000 (k=-7, 1 step):
- CLIP=1 -> out=0xFFFF, clipping 1.
- CLIP=0 -> out=0x2C00, clipping 1.
- Both at latency 3.
REQ-033 The bench SHALL cover special inputs, each at latency 2:
- -2.0f 0xC0000000 -> 0x0000, clipping 1.
- NaN 0x7FC00000 -> 0x0000, clipping 1.
- +inf 0x7F800000 -> 0xFFFF, clipping 1.
- -0.0f 0x80000000 -> 0x0000, clipping 0.
REQ-034 The bench SHALL cover underflow, 2^-10 in=0x3A800000 (k=-25) -> out 0x0000, clipping 0, latency 2.
REQ-035 The bench SHALL cover backpressure on 1.5f with out_ready low for 5 cycles -> out_valid, out and clipping stable, in_ready 0; after the handshake, in_ready 1 on the next cycle and the next operand accepted.
REQ-036 The bench SHALL cover reset pulsed for one cycle during ALIGN of 300.0f -> out_valid never asserts for that operand, and a following 1.5f yields 0x0180.
